// File: rtl/alu_issue.sv
// Single-issue front end for an external ALU: decodes RV32I ADD/SUB/SLT (plus
// ADDI/SLTI when ALU_ISSUE_IMM_EN is defined), issues the request, and returns the result for writeback.
package core_pkg;
  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_SLTS = 2'd2
  } alu_opcode_e;
endpackage

module alu_issue
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid_ip,
  output logic        instr_ready_op,
  input  logic [31:0] instr_ip,
  input  logic [31:0] rs1_data_ip,
  input  logic [31:0] rs2_data_ip,
  output logic        alu_enable_op,
  output alu_opcode_e alu_operator_op,
  output logic [31:0] alu_operand_a_op,
  output logic [31:0] alu_operand_b_op,
  input  logic [31:0] alu_result_ip,
  input  logic        alu_valid_ip,
  output logic        wb_valid_op,
  input  logic        wb_ready_ip,
  output logic [4:0]  wb_rd_op,
  output logic [31:0] wb_data_op,
  output logic        illegal_op
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_e;

  state_e      state_reg, state_next;
  alu_opcode_e op_reg;
  logic [31:0] a_reg, b_reg, result_reg;
  logic [4:0]  rd_reg;
  logic        illegal_reg;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        accept, dec_legal;
  alu_opcode_e dec_op;
  logic [31:0] dec_b;
  logic        unused_bits;

  assign opcode      = instr_ip[6:0];
  assign funct3      = instr_ip[14:12];
  assign funct7      = instr_ip[31:25];
  assign unused_bits = ^instr_ip[24:15];
  assign accept      = (state_reg == IDLE) && instr_valid_ip;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_ADD;
    dec_b     = rs2_data_ip;
    if (opcode == 7'b0110011) begin
      if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
        dec_legal = 1'b1;
        dec_op    = ALU_ADD;
      end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
        dec_legal = 1'b1;
        dec_op    = ALU_SUB;
      end else if (funct3 == 3'b010 && funct7 == 7'b0000000) begin
        dec_legal = 1'b1;
        dec_op    = ALU_SLTS;
      end
    end
`ifdef ALU_ISSUE_IMM_EN
    else if (opcode == 7'b0010011) begin
      dec_b = {{20{instr_ip[31]}}, instr_ip[31:20]};
      if (funct3 == 3'b000) begin
        dec_legal = 1'b1;
        dec_op    = ALU_ADD;
      end else if (funct3 == 3'b010) begin
        dec_legal = 1'b1;
        dec_op    = ALU_SLTS;
      end
    end
`endif
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && dec_legal) state_next = ISSUE;
      // Results targeting x0 are dropped without a writeback cycle
      ISSUE:   if (alu_valid_ip) state_next = (rd_reg != 5'd0) ? WB : IDLE;
      WB:      if (wb_ready_ip) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg      <= ALU_ADD;
      a_reg       <= '0;
      b_reg       <= '0;
      rd_reg      <= '0;
      result_reg  <= '0;
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= accept && !dec_legal;
      if (accept && dec_legal) begin
        op_reg <= dec_op;
        a_reg  <= rs1_data_ip;
        b_reg  <= dec_b;
        rd_reg <= instr_ip[11:7];
      end
      if (state_reg == ISSUE && alu_valid_ip) result_reg <= alu_result_ip;
    end
  end

  always_comb begin
    instr_ready_op   = (state_reg == IDLE);
    alu_enable_op    = 1'b0;
    alu_operator_op  = ALU_ADD;
    alu_operand_a_op = '0;
    alu_operand_b_op = '0;
    wb_valid_op      = 1'b0;
    wb_rd_op         = '0;
    wb_data_op       = '0;
    illegal_op       = illegal_reg;
    if (state_reg == ISSUE) begin
      alu_enable_op    = 1'b1;
      alu_operator_op  = op_reg;
      alu_operand_a_op = a_reg;
      alu_operand_b_op = b_reg;
    end
    if (state_reg == WB) begin
      wb_valid_op = 1'b1;
      wb_rd_op    = rd_reg;
      wb_data_op  = result_reg;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed vector table, reset corner sequences and
// randomized instructions checked against an instruction-level reference model.
module tb_alu_issue;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid_ip = 1'b0;
  logic        instr_ready_op;
  logic [31:0] instr_ip = '0;
  logic [31:0] rs1_data_ip = '0;
  logic [31:0] rs2_data_ip = '0;
  logic        alu_enable_op;
  alu_opcode_e alu_operator_op;
  logic [31:0] alu_operand_a_op, alu_operand_b_op;
  logic [31:0] alu_result_ip;
  logic        alu_valid_ip;
  logic        wb_valid_op;
  logic        wb_ready_ip = 1'b0;
  logic [4:0]  wb_rd_op;
  logic [31:0] wb_data_op;
  logic        illegal_op;
  logic        alu_rdy = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .reset(reset),
    .instr_valid_ip(instr_valid_ip), .instr_ready_op(instr_ready_op),
    .instr_ip(instr_ip), .rs1_data_ip(rs1_data_ip), .rs2_data_ip(rs2_data_ip),
    .alu_enable_op(alu_enable_op), .alu_operator_op(alu_operator_op),
    .alu_operand_a_op(alu_operand_a_op), .alu_operand_b_op(alu_operand_b_op),
    .alu_result_ip(alu_result_ip), .alu_valid_ip(alu_valid_ip),
    .wb_valid_op(wb_valid_op), .wb_ready_ip(wb_ready_ip),
    .wb_rd_op(wb_rd_op), .wb_data_op(wb_data_op), .illegal_op(illegal_op)
  );

  // External ALU stand-in: answers in the same cycle whenever alu_rdy allows
  function automatic logic [31:0] alu_stub(alu_opcode_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLTS: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:  return 32'hDEADBEEF;
    endcase
  endfunction

  assign alu_valid_ip  = alu_enable_op & alu_rdy;
  assign alu_result_ip = alu_stub(alu_operator_op, alu_operand_a_op, alu_operand_b_op);

  typedef struct {
    logic [31:0] instr, rs1, rs2;
    int          alu_dly, wb_stall;
    logic        ill;
    alu_opcode_e op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(logic [31:0] instr, logic [31:0] rs1, logic [31:0] rs2,
                              int dly, int stall, logic ill, alu_opcode_e op,
                              logic [31:0] a, logic [31:0] b, logic [4:0] rd, logic [31:0] data);
    vec_t v;
    v.instr = instr; v.rs1 = rs1; v.rs2 = rs2; v.alu_dly = dly; v.wb_stall = stall;
    v.ill = ill; v.op = op; v.a = a; v.b = b; v.rd = rd; v.data = data;
    return v;
  endfunction

  // Instruction-level reference: what the architecture says the instruction computes
  function automatic vec_t ref_model(logic [31:0] instr, logic [31:0] rs1, logic [31:0] rs2);
    vec_t v;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm;
    opc = instr[6:0]; f3 = instr[14:12]; f7 = instr[31:25];
    imm = 32'($signed(instr[31:20]));
    v = mk(instr, rs1, rs2, 0, 0, 1'b1, ALU_ADD, 0, 0, 0, 0);
    v.rd = instr[11:7];
    v.a  = rs1;
    if (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h00) begin
      v.ill = 0; v.op = ALU_ADD;  v.b = rs2; v.data = rs1 + rs2;
    end else if (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin
      v.ill = 0; v.op = ALU_SUB;  v.b = rs2; v.data = rs1 - rs2;
    end else if (opc == 7'h33 && f3 == 3'd2 && f7 == 7'h00) begin
      v.ill = 0; v.op = ALU_SLTS; v.b = rs2;
      v.data = ($signed(rs1) < $signed(rs2)) ? 32'd1 : 32'd0;
    end
`ifdef ALU_ISSUE_IMM_EN
    else if (opc == 7'h13 && f3 == 3'd0) begin
      v.ill = 0; v.op = ALU_ADD;  v.b = imm; v.data = rs1 + imm;
    end else if (opc == 7'h13 && f3 == 3'd2) begin
      v.ill = 0; v.op = ALU_SLTS; v.b = imm;
      v.data = ($signed(rs1) < $signed(imm)) ? 32'd1 : 32'd0;
    end
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ready"},    32'(instr_ready_op), 32'd1);
    check({tag, " alu_en"},   32'(alu_enable_op), 32'd0);
    check({tag, " alu_op"},   32'(alu_operator_op), 32'(ALU_ADD));
    check({tag, " opa"},      alu_operand_a_op, 32'd0);
    check({tag, " opb"},      alu_operand_b_op, 32'd0);
    check({tag, " wb_valid"}, 32'(wb_valid_op), 32'd0);
    check({tag, " wb_data"},  wb_data_op, 32'd0);
    check({tag, " wb_rd"},    32'(wb_rd_op), 32'd0);
    check({tag, " illegal"},  32'(illegal_op), 32'd0);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic do_txn(input vec_t v, input string tag);
    check({tag, " ready_pre"}, 32'(instr_ready_op), 32'd1);
    instr_ip = v.instr; rs1_data_ip = v.rs1; rs2_data_ip = v.rs2;
    instr_valid_ip = 1'b1;
    alu_rdy = (v.alu_dly == 0);
    @(posedge clk); #1;
    if (v.ill) begin
      instr_valid_ip = 1'b0;
      check({tag, " ill_pulse"},  32'(illegal_op), 32'd1);
      check({tag, " ill_alu_en"}, 32'(alu_enable_op), 32'd0);
      check({tag, " ill_wb"},     32'(wb_valid_op), 32'd0);
      check({tag, " ill_ready"},  32'(instr_ready_op), 32'd1);
      @(posedge clk); #1;
      check({tag, " ill_clear"},  32'(illegal_op), 32'd0);
      check({tag, " ill_alu_en2"}, 32'(alu_enable_op), 32'd0);
      return;
    end
    // Offer an unsupported instruction while busy: it must not be taken
    instr_ip = 32'h0020C1B3;
    check({tag, " no_ill"}, 32'(illegal_op), 32'd0);
    for (int d = 0; d <= v.alu_dly; d++) begin
      alu_rdy = (d == v.alu_dly);
      check({tag, " alu_en"}, 32'(alu_enable_op), 32'd1);
      check({tag, " alu_op"}, 32'(alu_operator_op), 32'(v.op));
      check({tag, " opa"},    alu_operand_a_op, v.a);
      check({tag, " opb"},    alu_operand_b_op, v.b);
      check({tag, " busy_ready"}, 32'(instr_ready_op), 32'd0);
      @(posedge clk); #1;
    end
    alu_rdy = 1'b0;
    if (v.rd != 5'd0) begin
      for (int s = 0; s <= v.wb_stall; s++) begin
        wb_ready_ip = (s == v.wb_stall);
        check({tag, " wb_valid"}, 32'(wb_valid_op), 32'd1);
        check({tag, " wb_rd"},    32'(wb_rd_op), 32'(v.rd));
        check({tag, " wb_data"},  wb_data_op, v.data);
        check({tag, " wb_ready_out"}, 32'(instr_ready_op), 32'd0);
        check({tag, " wb_alu_en"}, 32'(alu_enable_op), 32'd0);
        @(posedge clk); #1;
      end
      wb_ready_ip = 1'b0;
    end
    instr_valid_ip = 1'b0;
    check({tag, " end_wb"},    32'(wb_valid_op), 32'd0);
    check({tag, " end_ready"}, 32'(instr_ready_op), 32'd1);
    check({tag, " end_ill"},   32'(illegal_op), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(32'h002081B3, 5, 7, 0, 0, 0, ALU_ADD, 5, 7, 3, 12);
    vecs[1] = mk(32'h402081B3, 3, 5, 0, 0, 0, ALU_SUB, 3, 5, 3, 32'hFFFFFFFE);
    vecs[2] = mk(32'h0020A1B3, 32'hFFFFFFFF, 1, 0, 0, 0, ALU_SLTS, 32'hFFFFFFFF, 1, 3, 1);
    vecs[3] = mk(32'h0020C1B3, 1, 2, 0, 0, 1, ALU_ADD, 0, 0, 0, 0);
    vecs[4] = mk(32'h00208033, 1, 2, 0, 0, 0, ALU_ADD, 1, 2, 0, 0);
`ifdef ALU_ISSUE_IMM_EN
    vecs[5] = mk(32'hFFF08293, 10, 0, 0, 0, 0, ALU_ADD, 10, 32'hFFFFFFFF, 5, 9);
`else
    vecs[5] = mk(32'hFFF08293, 10, 0, 0, 0, 1, ALU_ADD, 0, 0, 0, 0);
`endif
    vecs[6] = mk(32'h022081B3, 4, 4, 0, 0, 1, ALU_ADD, 0, 0, 0, 0);
    vecs[7] = mk(32'h4020A1B3, 4, 4, 0, 0, 1, ALU_ADD, 0, 0, 0, 0);
    vecs[8] = mk(32'h002081B3, 100, 32'hFFFFFFFF, 2, 5, 0, ALU_ADD, 100, 32'hFFFFFFFF, 3, 99);
    vecs[9] = mk(32'h0020A1B3, 5, 3, 1, 1, 0, ALU_SLTS, 5, 3, 3, 0);

    #1;
    check_idle_outputs("reset");
    #11 reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");

    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i], $sformatf("vec%0d", i));
      $display("vec %0d instr %h applied", i, vecs[i].instr);
    end

    // Reset during WB: writeback vanishes at once and never returns
    alu_rdy = 1'b1;
    instr_ip = 32'h002081B3; rs1_data_ip = 5; rs2_data_ip = 7; instr_valid_ip = 1'b1;
    @(posedge clk); #1 instr_valid_ip = 1'b0;
    @(posedge clk); #1;
    alu_rdy = 1'b0;
    check("rstwb in_wb", 32'(wb_valid_op), 32'd1);
    #2 reset = 1'b0;
    #1 check_idle_outputs("rstwb async");
    #1 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rstwb after wb_valid", 32'(wb_valid_op), 32'd0);
      check("rstwb after ready", 32'(instr_ready_op), 32'd1);
    end
    $display("seq reset_in_wb applied");

    // Reset during ISSUE: request dropped, nothing follows
    alu_rdy = 1'b0;
    instr_ip = 32'h402081B3; rs1_data_ip = 9; rs2_data_ip = 1; instr_valid_ip = 1'b1;
    @(posedge clk); #1 instr_valid_ip = 1'b0;
    check("rstiss in_issue", 32'(alu_enable_op), 32'd1);
    #2 reset = 1'b0;
    #1 check_idle_outputs("rstiss async");
    #1 reset = 1'b1;
    alu_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rstiss after alu_en", 32'(alu_enable_op), 32'd0);
      check("rstiss after wb_valid", 32'(wb_valid_op), 32'd0);
    end
    alu_rdy = 1'b0;
    $display("seq reset_in_issue applied");

    for (int i = 0; i < 300; i++) begin
      logic [6:0] opc, f7;
      logic [2:0] f3;
      logic [31:0] instr, r1, r2;
      vec_t v;
      case ($urandom_range(0, 3))
        0, 1:    opc = 7'h33;
        2:       opc = 7'h13;
        default: opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       f3 = 3'd0;
        1:       f3 = 3'd2;
        default: f3 = 3'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      instr = {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc};
      r1 = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      r2 = ($urandom_range(0, 4) == 0) ? 32'h7FFFFFFF : $urandom;
      v = ref_model(instr, r1, r2);
      v.alu_dly  = $urandom_range(0, 2);
      v.wb_stall = $urandom_range(0, 2);
      do_txn(v, $sformatf("rnd%0d", i));
      $display("rnd %0d instr %h applied", i, instr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL provide: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL provide: reset  input  1  asynchronous active-low reset.
REQ-003 SHALL provide: instr_valid_ip  input  1  instruction offered.
REQ-004 SHALL provide: instr_ready_op  output  1  block can accept an instruction.
REQ-005 SHALL provide: instr_ip  input  32  RV32I instruction word.
REQ-006 SHALL provide: rs1_data_ip  input  32  rs1 register value, valid with instr_valid_ip.
REQ-007 SHALL provide: rs2_data_ip  input  32  rs2 register value, valid with instr_valid_ip.
REQ-008 SHALL provide: alu_enable_op  output  1  ALU request.
REQ-009 SHALL provide: alu_operator_op  output  alu_opcode_e (CORE_PKG)  ALU_ADD, ALU_SUB or ALU_SLTS.
REQ-010 SHALL provide: alu_operand_a_op, alu_operand_b_op  output  32 each  ALU operands.
REQ-011 SHALL provide: alu_result_ip  input  32, alu_valid_ip  input  1  ALU response.
REQ-012 SHALL provide: wb_valid_op  output  1, wb_ready_ip  input  1  writeback handshake.
REQ-013 SHALL provide: wb_rd_op  output  5, wb_data_op  output  32  destination register and result.
REQ-014 SHALL provide: illegal_op  output  1  one-cycle pulse for an unsupported instruction.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WB; instr_ready_op = 1 only in IDLE.
REQ-016 In IDLE, instr_valid_ip && instr_ready_op at an edge SHALL register instruction fields and rs1/rs2 data, decode, and go to ISSUE (legal) or stay IDLE (illegal).
REQ-017 Decode: opcode 0110011 with funct3 000/funct7 0000000 -> ALU_ADD; funct3 000/funct7 0100000 -> ALU_SUB; funct3 010/funct7 0000000 -> ALU_SLTS; operand_a = rs1, operand_b = rs2.
REQ-018 Any other encoding SHALL be illegal: illegal_op high exactly one cycle after the accept edge, no ALU request, no writeback.
REQ-019 In ISSUE, alu_enable_op SHALL be 1 with registered operator/operands held stable; outside ISSUE alu_enable_op = 0, operator = ALU_ADD, operands = 0.
REQ-020 In ISSUE, an edge with alu_valid_ip = 1 SHALL capture alu_result_ip; the block SHALL stay in ISSUE while alu_valid_ip = 0.
REQ-021 After capture with rd != 0 SHALL go to WB; with rd == 0 SHALL discard the result and return to IDLE, no wb_valid_op.
REQ-022 In WB, wb_valid_op = 1 with wb_rd_op/wb_data_op held stable until an edge with wb_ready_ip = 1, then return to IDLE; outside WB wb_valid_op = 0.
REQ-023 With a same-cycle ALU, latency SHALL be: accept edge N, ISSUE cycle N+1, wb_valid_op high from cycle N+2.
REQ-024 instr_valid_ip outside IDLE SHALL be ignored (not accepted, no state change).

Reset
REQ-025 reset low SHALL immediately force IDLE; instr_ready_op = 1, all other outputs 0, alu_operator_op = ALU_ADD, regardless of current state.
REQ-026 Reset asserted mid-ISSUE or mid-WB SHALL drop the in-flight operation with no writeback after release.

Configuration
REQ-027 Macro ALU_ISSUE_IMM_EN defined: opcode 0010011 funct3 000 -> ALU_ADD (ADDI), funct3 010 -> ALU_SLTS (SLTI), operand_b = sign-extended instr[31:20].
REQ-028 Macro ALU_ISSUE_IMM_EN undefined: opcode 0010011 SHALL be illegal per REQ-018.

Verification
REQ-029 instr 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 -> ALU_ADD, operands 5/7, wb_rd_op=3, wb_data_op=12, wb_valid_op at N+2.
REQ-030 instr 0x402081B3 (sub), rs1=3, rs2=5 -> ALU_SUB, wb_data_op=0xFFFFFFFE; 0x0020A1B3 (slt), rs1=0xFFFFFFFF, rs2=1 -> ALU_SLTS, wb_data_op=1.
REQ-031 instr 0x0020C1B3 (xor) -> illegal_op one-cycle pulse, alu_enable_op and wb_valid_op stay 0, instr_ready_op remains 1.
REQ-032 instr 0x00208033 (add x0) -> ALU request issued, no wb_valid_op, back in IDLE at N+2.
REQ-033 wb_ready_ip held 0 for 5 cycles -> wb_valid_op/wb_data_op stable, instr_ready_op 0; reset pulsed during WB -> wb_valid_op 0 immediately.
REQ-034 With ALU_ISSUE_IMM_EN: 0xFFF08293 (addi x5,x1,-1), rs1=10 -> operand_b=0xFFFFFFFF, wb_data_op=9; without it -> illegal_op pulse.
